lsu_mem_initiator: RTL and testbench

- Load/store initiator that sits between the RV32 core execute stage and the word-granular data memory.
- The data memory is 32-bit word addressed: address bits [31:2], a combinational read, and a synchronous full-word write on we.
- This block performs byte/halfword/word loads with sign or zero extension.
- Sub-word stores are done as a read-modify-write sequence, behind a valid/ready request and a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_align.sv | 36 +++
 rtl/lsu_mem_initiator.sv | 116 +++++++++++
 tb/tb_lsu_mem_initiator.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and access-legality helpers for the load/store initiator.
package lsu_pkg;
    localparam int DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_RMW_RD = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LOAD   = ST_LOAD,
        RMW_RD = ST_RMW_RD,
        WRITE  = ST_WRITE,
        RESP   = ST_RESP
    } state_t;

    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_H, F3_HU: return a[0];
            F3_W:        return a != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/lsu_align.sv
// Byte/halfword lane logic: load extraction with extension and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] rd,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] st_word
);
    logic [7:0]  byte_l;
    logic [15:0] half_l;

    always_comb begin
        byte_l = rd[{addr_lo, 3'b000} +: 8];
        half_l = addr_lo[1] ? rd[31:16] : rd[15:0];
        case (funct3)
            F3_B:    ld_data = {{24{byte_l[7]}}, byte_l};
            F3_BU:   ld_data = {24'h0, byte_l};
            F3_H:    ld_data = {{16{half_l[15]}}, half_l};
            F3_HU:   ld_data = {16'h0, half_l};
            default: ld_data = rd;
        endcase
    end

    always_comb begin
        st_word = rd;
        if (funct3 == F3_B)
            st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        else if (funct3 == F3_H) begin
            if (addr_lo[1]) st_word[31:16] = wdata[15:0];
            else            st_word[15:0]  = wdata[15:0];
        end
    end
endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for a word-addressed memory; sub-word stores via read-modify-write.
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);
    state_t      state;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic [31:0] ld_data, st_word;
    logic        misal;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misal = misaligned(req_funct3, req_addr[1:0]);
`else
    assign misal = 1'b0;
`endif

    lsu_align u_align (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .rd      (mem_rd),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    // mem_a is only loaded on acceptance so the combinational read stays stable to RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_we    <= 1'b0;
            mem_a     <= '0;
            mem_wd    <= '0;
            store_q   <= 1'b0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            wdata_q   <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    store_q   <= req_store;
                    funct3_q  <= req_funct3;
                    addr_lo_q <= req_addr[1:0];
                    wdata_q   <= req_wdata;
                    mem_a     <= {req_addr[ADDR_W-1:2], 2'b00};
                    req_ready <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    if (!f3_legal(req_store, req_funct3) || misal) begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (!req_store) begin
                        state <= LOAD;
                    end else if (req_funct3 == F3_W) begin
                        mem_wd <= req_wdata;
                        mem_we <= 1'b1;
                        state  <= WRITE;
                    end else begin
                        state <= RMW_RD;
                    end
                end
                LOAD: begin
                    rsp_rdata <= store_q ? '0 : ld_data;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RMW_RD: begin
                    mem_wd <= st_word;
                    mem_we <= 1'b1;
                    state  <= WRITE;
                end
                WRITE: begin
                    mem_we    <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    mem_we    <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator with a behavioural word memory.
module tb_lsu_mem_initiator;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    lsu_mem_initiator dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [0:63];
    logic        booted = 1'b0;
    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) begin
        if (!booted) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[1]  <= 32'hCAFE_F00D;
            mem[4]  <= 32'h8000_0080;
            mem[8]  <= 32'h1234_ABCD;
            mem[12] <= 32'h1122_3344;
            mem[16] <= 32'hDEAD_BEEF;
            mem[21] <= 32'h5566_7788;
            booted  <= 1'b1;
        end else if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we;
        logic [31:0] wd;
        int          acc;
        int          we_base;
    } exp_t;
    exp_t sbq[$];
    int   we_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (mem_we) begin
                we_cnt++;
                if (sbq.size() > 0) chk({sbq[0].tag, ".wd"}, mem_wd, sbq[0].wd);
            end
            if (rsp_valid) begin
                if (sbq.size() == 0) chk("unexp_rsp", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk({e.tag, ".rdata"}, rsp_rdata, e.rdata);
                    chk({e.tag, ".err"}, {31'h0, rsp_err}, {31'h0, e.err});
                    chk({e.tag, ".lat"}, cyc - e.acc, e.lat);
                    chk({e.tag, ".we"}, we_cnt - e.we_base, e.we);
                end
            end
        end
    end

    task automatic issue(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eerr, input int elat,
                         input int ewe, input logic [31:0] ewd, input bit push);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk({tag, ".ready_to"}, 32'd0, 32'd1);
            return;
        end
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        if (push) sbq.push_back('{tag, erd, eerr, elat, ewe, ewd, cyc, we_cnt});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst.ready", {31'h0, req_ready}, 32'd1);
        chk("rst.rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.we", {31'h0, mem_we}, 32'd0);
        chk("rst.mem_a", mem_a, 32'd0);
        chk("rst.mem_wd", mem_wd, 32'd0);
        reset = 1'b1;

        issue("lb",   1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0, 32'h0, 1'b1);
        issue("lbu",  1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 2, 0, 32'h0, 1'b1);
        issue("lh_u", 1'b0, 3'b001, 32'h22, 32'h0, 32'h0000_1234, 1'b0, 2, 0, 32'h0, 1'b1);
        issue("lh_l", 1'b0, 3'b001, 32'h20, 32'h0, 32'hFFFF_ABCD, 1'b0, 2, 0, 32'h0, 1'b1);
        issue("sb",   1'b1, 3'b000, 32'h31, 32'hAA, 32'h0, 1'b0, 3, 1, 32'h1122_AA44, 1'b1);
        issue("lw_sb",1'b0, 3'b010, 32'h30, 32'h0, 32'h1122_AA44, 1'b0, 2, 0, 32'h0, 1'b1);
`ifdef LSU_MISALIGN_TRAP_EN
        issue("lw_mis", 1'b0, 3'b010, 32'h06, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 1'b1);
        issue("lh_mis", 1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 1'b1);
`else
        issue("lw_mis", 1'b0, 3'b010, 32'h06, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 0, 32'h0, 1'b1);
        issue("lh_mis", 1'b0, 3'b001, 32'h21, 32'h0, 32'hFFFF_ABCD, 1'b0, 2, 0, 32'h0, 1'b1);
`endif
        issue("ill_ld", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 1'b1);
        issue("ill_st", 1'b1, 3'b100, 32'h10, 32'h55, 32'h0, 1'b1, 1, 0, 32'h0, 1'b1);
        issue("sw",   1'b1, 3'b010, 32'h50, 32'h0102_0304, 32'h0, 1'b0, 2, 1, 32'h0102_0304, 1'b1);
        issue("lhu",  1'b0, 3'b101, 32'h52, 32'h0, 32'h0000_0102, 1'b0, 2, 0, 32'h0, 1'b1);
        issue("lb_p", 1'b0, 3'b000, 32'h53, 32'h0, 32'h0000_0001, 1'b0, 2, 0, 32'h0, 1'b1);
        issue("sh",   1'b1, 3'b001, 32'h56, 32'hBEEF, 32'h0, 1'b0, 3, 1, 32'hBEEF_7788, 1'b1);
        issue("lh_sh",1'b0, 3'b001, 32'h56, 32'h0, 32'hFFFF_BEEF, 1'b0, 2, 0, 32'h0, 1'b1);

        // abort an SH in its WRITE cycle; no response is expected
        issue("sh_rst", 1'b1, 3'b001, 32'h42, 32'h5555, 32'h0, 1'b0, 0, 0, 32'h0, 1'b0);
        begin
            int n = 0;
            @(negedge clk);
            while (!mem_we && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("rst_mid.saw_we", {31'h0, mem_we}, 32'd1);
            reset = 1'b0;
            #1;
            chk("rst_mid.we", {31'h0, mem_we}, 32'd0);
            chk("rst_mid.ready", {31'h0, req_ready}, 32'd1);
            chk("rst_mid.rsp", {31'h0, rsp_valid}, 32'd0);
            repeat (2) @(negedge clk);
            chk("rst_mid.mem", mem[16], 32'hDEAD_BEEF);
            reset = 1'b1;
        end

        issue("sw2", 1'b1, 3'b010, 32'h40, 32'h0BAD_F00D, 32'h0, 1'b0, 2, 1, 32'h0BAD_F00D, 1'b1);
        issue("lw2", 1'b0, 3'b010, 32'h40, 32'h0, 32'h0BAD_F00D, 1'b0, 2, 0, 32'h0, 1'b1);

        begin
            int n = 0;
            while (sbq.size() > 0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("drain", sbq.size(), 32'd0);
        end
        chk("mem_sb", mem[12], 32'h1122_AA44);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
